// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - iterative 32-bit divider with RV32M DIV/DIVU/REM/REMU results
//
// Restoring radix-2 divider. It produces one quotient bit per cycle and always
// returns both quotient and remainder.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   in_en       operand pair valid, accepted only while idle=1
//   a, b        dividend, divisor
//   div_signed  1 = two's-complement operands, 0 = unsigned
//   out_en      one-cycle pulse, q/rem valid
//   idle        1 = ready to accept a new operand pair
//   q, rem      quotient and remainder, held until the next out_en
module seq_divider32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        div_signed,
  output logic        out_en,
  output logic        idle,
  output logic [31:0] q,
  output logic [31:0] rem
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t      state_q, state_d;
  // dvd holds the dividend and receives quotient bits at its LSB as the
  // dividend bits shift out at its MSB, so it ends up holding the quotient.
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] pr_q, pr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        out_en_q, out_en_d;
  logic [31:0] q_q, q_d;
  logic [31:0] rem_q, rem_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] sub;

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    pr_d      = pr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    out_en_d  = 1'b0;
    q_d       = q_q;
    rem_d     = rem_q;

    // Negating 0x80000000 gives 0x80000000, which is the correct unsigned magnitude.
    abs_a = (div_signed && a[31]) ? -a : a;
    abs_b = (div_signed && b[31]) ? -b : b;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits. When the divisor fits, the difference is below the
    // divisor and its low 32 bits are exact.
    shifted = {pr_q, dvd_q[31]};
    fits    = shifted >= {1'b0, dvs_q};
    sub     = shifted[31:0] - dvs_q;

    case (state_q)
      S_IDLE: begin
        if (in_en) begin
          neg_quo_d = div_signed & (a[31] ^ b[31]);
          neg_rem_d = div_signed & a[31];
          dvd_d     = abs_a;
          dvs_d     = abs_b;
          pr_d      = 32'd0;
          cnt_d     = 5'd0;
          state_d   = S_CALC;
          // Special cases preload the final raw result and clear the sign
          // flags, so FIN passes the result through unchanged.
          if (b == 32'd0) begin
            dvd_d     = 32'hFFFF_FFFF;
            pr_d      = a;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIN;
          end else if (div_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            dvd_d     = 32'h8000_0000;
            pr_d      = 32'd0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIN;
          end
        end
      end
      S_CALC: begin
        if (fits) begin
          pr_d  = sub;
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          pr_d  = shifted[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        q_d      = neg_quo_q ? -dvd_q : dvd_q;
        rem_d    = neg_rem_q ? -pr_q : pr_q;
        out_en_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      pr_q      <= 32'd0;
      cnt_q     <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      out_en_q  <= 1'b0;
      q_q       <= 32'd0;
      rem_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      pr_q      <= pr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      out_en_q  <= out_en_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
    end
  end

  assign out_en = out_en_q;
  assign idle   = (state_q == S_IDLE);
  assign q      = q_q;
  assign rem    = rem_q;

endmodule

// File: tb/tb_seq_divider32.sv
// tb/tb_seq_divider32.sv - scoreboard bench for seq_divider32 against an arithmetic model
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_en = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        div_signed = 1'b0;
  logic        out_en;
  logic        idle;
  logic [31:0] q;
  logic [31:0] rem;

  seq_divider32 dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .a(a), .b(b),
    .div_signed(div_signed), .out_en(out_en), .idle(idle), .q(q), .rem(rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] eq;
    logic [31:0] er;
    int          acc;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  logic        rst_samp = 1'b0;
  int          nchecks = 0;
  int          nerr = 0;
  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_samp <= rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchecks++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // RV32M semantics from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    int          sx, sy, sq, sr;
    logic [31:0] rq, rr;
    if (y == 32'd0) return {32'hFFFF_FFFF, x};
    if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      sx = x; sy = y;
      sq = sx / sy;
      sr = sx % sy;
      rq = sq; rr = sr;
      return {rq, rr};
    end
    rq = x / y; rr = x % y;
    return {rq, rr};
  endfunction

  always @(negedge clk) begin
    if (!rst_samp) begin
      sb.delete();
      chk("rst_out_en", {31'd0, out_en}, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);
      chk("rst_q", q, 32'd0);
      chk("rst_rem", rem, 32'd0);
      last_q = 32'd0;
      last_r = 32'd0;
    end else if (out_en) begin
      if (sb.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL spurious_out_en: got out_en=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", q, e.eq);
        chk("remainder", rem, e.er);
        chk("latency_cycle", cyc, e.exp_cyc);
        chk("idle_with_out_en", {31'd0, idle}, 32'd1);
        last_q = e.eq;
        last_r = e.er;
      end
    end else begin
      chk("hold_q", q, last_q);
      chk("hold_rem", rem, last_r);
      if (sb.size() > 0 && cyc > sb[0].acc && cyc < sb[0].exp_cyc)
        chk("busy_idle", {31'd0, idle}, 32'd0);
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is);
    int          w;
    logic [63:0] r;
    exp_t        e;
    w = 0;
    while (!idle && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!idle) begin
      nchecks++; nerr++;
      $display("FAIL idle_timeout: got idle=0 expected idle=1 within 200 cycles");
    end
    r = ref_div(ia, ib, is);
    e.eq = r[63:32];
    e.er = r[31:0];
    e.acc = cyc;
    e.exp_cyc = cyc + ((ib == 32'd0 || (is && ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF)) ? 2 : 34);
    sb.push_back(e);
    in_en = 1'b1; a = ia; b = ib; div_signed = is;
    @(posedge clk); #1;
    in_en = 1'b0; a = $urandom; b = $urandom; div_signed = 1'($urandom);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb.size() > 0 || !idle) && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (sb.size() > 0) begin
      nchecks++; nerr++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          k;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases; the second op goes in the cycle of the first out_en.
    issue(32'd100, 32'd7, 1'b0);
    issue(32'd9, 32'd3, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(32'd5, 32'd0, 1'b0);
    issue(32'd5, 32'd0, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'h8000_0000, 32'd1, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_drain();

    // in_en pulse while busy must be ignored.
    issue(32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1 in_en = 1'b1; a = 32'd9; b = 32'd3; div_signed = 1'b0;
    @(posedge clk); #1 in_en = 1'b0;
    wait_drain();

    // Reset sampled at E10 of a divide discards it.
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0; in_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1; in_en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(32'd100, 32'd7, 1'b0);
    wait_drain();

    // Randomized operands, including special cases and random idle gaps.
    for (int i = 0; i < 30; i++) begin
      k  = $urandom_range(0, 9);
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (k == 0) rb = 32'd0;
      else if (k == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
      else if (k <= 4) rb = $urandom_range(1, 20);
      else if (k == 5) ra = $urandom_range(0, 50);
      issue(ra, rb, rs);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 40)) @(posedge clk);
        #1;
      end
    end
    wait_drain();
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
